mem_port: RTL
=============

MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of bus, MDR and memory data.
REQ-002 SHALL provide parameter ADDR_W, default 9, width of MAR and memory address.
REQ-003 SHALL provide parameter TIMEOUT, default 16, max cycles waiting for mem_ack (used only with MEM_PORT_TIMEOUT_EN).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have bus_in  input  DATA_W  internal CPU bus value.
REQ-007 SHALL have mar_load  input  1  capture bus_in[ADDR_W-1:0] into MAR.
REQ-008 SHALL have mdr_load  input  1  capture bus_in into MDR.
REQ-009 SHALL have mdr_out  input  1  drive MDR onto bus_out.
REQ-010 SHALL have rd_req / wr_req  input  1 each  start memory read / write.
REQ-011 SHALL have bus_out  output  DATA_W  MDR when mdr_out=1, else 0.
REQ-012 SHALL have busy, done, err  output  1 each  access in progress / completion pulse / timeout.
REQ-013 SHALL have mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_re, mem_we  output  1.
REQ-014 SHALL have mem_rdata  input  DATA_W, mem_ack  input  1  memory completion strobe.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-016 IDLE: rd_req=1 at edge -> READ; else wr_req=1 -> WRITE; rd_req and wr_req both 1 -> READ, write discarded.
REQ-017 mem_addr SHALL equal MAR; mem_wdata SHALL equal MDR; mem_re=1 only in READ, mem_we=1 only in WRITE.
REQ-018 READ with mem_ack=1 at edge: MDR <= mem_rdata, state -> DONE (ack latency 0 cycles after request legal: earliest DONE is 2 edges after rd_req).
REQ-019 WRITE with mem_ack=1 at edge: state -> DONE, MDR unchanged.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE unconditionally; requests in DONE ignored.
REQ-021 busy=1 in READ, WRITE, DONE; 0 in IDLE.
REQ-022 mar_load/mdr_load SHALL be honoured only in IDLE; ignored while busy=1 (MAR/MDR frozen during access).
REQ-023 mar_load and mdr_load together in IDLE SHALL both take effect same edge; mdr_load and rd_req together: MDR loads, read starts.
REQ-024 bus_out SHALL be combinational from MDR and mdr_out, valid in any state.
REQ-025 mem_ack in IDLE or DONE SHALL be ignored.

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE, MAR=0, MDR=0, err=0; thus busy=0, done=0, mem_re=0, mem_we=0, bus_out=0 (with mdr_out=0), mem_addr=0.
REQ-027 reset mid-access SHALL abort it with no done pulse; pending ack after release ignored.

Configuration
REQ-028 Macro MEM_PORT_TIMEOUT_EN defined: cycle counter runs in READ/WRITE; if TIMEOUT cycles elapse without mem_ack -> DONE with err=1 (sticky until next request accepted or reset), MDR unchanged.
REQ-029 Macro undefined: no counter, READ/WRITE wait indefinitely, err tied 0.

Structure
REQ-030 Package mem_port_pkg SHALL hold FSM state typedef and default width constants.
REQ-031 Sub-module mem_port_timer (watchdog counter, clear/enable/expired) SHALL be instantiated only under MEM_PORT_TIMEOUT_EN.

Verification
REQ-032 reset=1 mid-READ -> busy=0, mem_re=0 immediately; MDR=0.
REQ-033 bus_in=0x005, mar_load; bus_in=0xDEADBEEF, mdr_load; wr_req; mem_ack 3 cycles later -> mem_we=1 with mem_addr=0x005, mem_wdata=0xDEADBEEF; done one cycle.
REQ-034 MAR=0x012, rd_req, mem_rdata=0x12345678 with mem_ack -> MDR=0x12345678; mdr_out=1 -> bus_out=0x12345678; mdr_out=0 -> bus_out=0.
REQ-035 rd_req and wr_req same cycle -> mem_re=1, mem_we never asserted.
REQ-036 mdr_load with bus_in=0xFFFFFFFF during READ -> MDR keeps value until ack data.
REQ-037 With MEM_PORT_TIMEOUT_EN, rd_req and no ack -> err=1, done pulse after 16 cycles; next rd_req clears err.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and default widths for the CPU memory port.
package mem_port_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_port_timer.sv
// Watchdog cycle counter for memory accesses. Flags expiry on the cycle
// where TIMEOUT enabled cycles have been seen without a clear.
module mem_port_timer
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles; clear wins, and the count holds once expired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port.sv
// CPU memory port: MAR/MDR registers plus a small read/write handshake FSM
// toward a memory with a completion strobe (mem_ack).
// Optional feature: define MEM_PORT_TIMEOUT_EN to add a watchdog that ends
// an unacknowledged access after TIMEOUT cycles and raises a sticky err.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_load,
  input  logic              mdr_load,
  input  logic              mdr_out,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] bus_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              tmo_expired;

`ifdef MEM_PORT_TIMEOUT_EN
  logic tmo_en;
  logic err_q;
  logic req_accept;

  assign tmo_en     = (state == ST_READ) || (state == ST_WRITE);
  assign req_accept = (state == ST_IDLE) && (rd_req || wr_req);

  mem_port_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!tmo_en),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  // err is set by a timeout that is not rescued by a same-cycle ack and
  // stays set until the next accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (req_accept) begin
      err_q <= 1'b0;
    end else if (tmo_expired && !mem_ack) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo_expired = 1'b0;
  assign err         = 1'b0;

  // TIMEOUT only matters with the watchdog; keep it referenced so the
  // parameter list is identical in both builds.
  if (TIMEOUT < 1) begin : g_tmo_unused
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and decoded control outputs; read wins over write.
  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (rd_req) begin
          state_nxt = ST_READ;
        end else if (wr_req) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_READ: begin
        mem_re = 1'b1;
        if (mem_ack || tmo_expired) begin
          state_nxt = ST_DONE;
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (mem_ack || tmo_expired) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // MAR/MDR: bus loads only while idle; read data lands in MDR on ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (mar_load) begin
          mar <= bus_in[ADDR_W-1:0];
        end
        if (mdr_load) begin
          mdr <= bus_in;
        end
      end else if ((state == ST_READ) && mem_ack) begin
        mdr <= mem_rdata;
      end
    end
  end

  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign bus_out   = mdr_out ? mdr : '0;

endmodule
